// File: rtl/arith_pkg.sv
// Shared constants and types for the arithmetic unit's divide path.
// Contents: operand width, iteration-count width, divider state
// encoding and the result payload carried to the controlling logic.
package arith_pkg;

  // Operand / quotient / remainder width.
  localparam int unsigned WIDTH = 8;

  // Iteration counter width; wide enough to hold WIDTH itself.
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Result payload presented by the divider.
  typedef struct packed {
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
  } div_result_t;

endpackage : arith_pkg

// File: rtl/div_sub_stage.sv
// Combinational trial subtractor for one restoring-division step.
// Computes a - b as a + ~b + 1 over WIDTH+1 bits, the same invert-B /
// carry-in-1 scheme as the add/sub datapath.
// Ports:
//   a           : partial remainder after the left shift (WIDTH+1 bits)
//   b           : zero-extended divisor (WIDTH+1 bits)
//   diff_c      : low WIDTH bits of a - b (valid as a remainder when no_borrow_c)
//   no_borrow_c : carry-out of the add, high when a >= b
module div_sub_stage
  import arith_pkg::*;
(
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   b,
  output logic [WIDTH-1:0] diff_c,
  output logic             no_borrow_c
);

  localparam int unsigned SUM_W = WIDTH + 2;

  logic [SUM_W-1:0] sum;
  logic             diff_msb_unused;

  // Extra top bit captures the carry-out of the inverted-operand add.
  assign sum = {1'b0, a} + {1'b0, ~b} + SUM_W'(1);

  // When there is no borrow the difference is below the divisor, so its
  // top data bit is always zero and only WIDTH bits are forwarded.
  assign {no_borrow_c, diff_msb_unused, diff_c} = sum;

endmodule : div_sub_stage

// File: rtl/seq_divider8.sv
// Sequential unsigned restoring divider, one trial subtraction per clock.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   start       : division request, honoured only when idle
//   dividend    : numerator, captured on the accepted start edge
//   divisor     : denominator, captured on the accepted start edge
//   busy        : high while iterating
//   done        : one-cycle pulse when results become valid
//   quotient    : floor(dividend / divisor), 8'hFF on divide by zero
//   remainder   : dividend mod divisor, dividend on divide by zero
//   div_by_zero : captured divisor was zero
module seq_divider8
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] RUN  = 2'(ST_RUN);
  localparam logic [1:0] DONE = 2'(ST_DONE);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state,   state_n;
  logic [WIDTH-1:0] rem_q,   rem_n;
  logic [WIDTH-1:0] quo_q,   quo_n;
  logic [WIDTH-1:0] dvs_q,   dvs_n;
  logic [CNT_W-1:0] cnt,     cnt_n;
  logic             busy_n;
  logic             done_n;
  div_result_t      res,     res_n;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH-1:0] trial_diff;
  logic             trial_ok;

  // Shift {R,Q} left by one; R grows to WIDTH+1 bits for the trial.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign quo_shift = {quo_q[WIDTH-2:0], 1'b0};

  // Single trial subtractor shared by every iteration.
  div_sub_stage u_sub (
    .a           (rem_shift),
    .b           ({1'b0, dvs_q}),
    .diff_c      (trial_diff),
    .no_borrow_c (trial_ok)
  );

  // State and datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
    end else begin
      state <= state_n;
      rem_q <= rem_n;
      quo_q <= quo_n;
      dvs_q <= dvs_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      res   <= res_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    rem_n   = rem_q;
    quo_n   = quo_q;
    dvs_n   = dvs_q;
    cnt_n   = cnt;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    res_n   = res;

    case (state)
      IDLE: begin
        if (start) begin
          dvs_n             = divisor;
          res_n.div_by_zero = 1'b0;
          if (divisor == '0) begin
            // Divide by zero completes immediately with fixed results.
            state_n           = DONE;
            done_n            = 1'b1;
            res_n.quotient    = '1;
            res_n.remainder   = dividend;
            res_n.div_by_zero = 1'b1;
          end else begin
            state_n = RUN;
            busy_n  = 1'b1;
            rem_n   = '0;
            quo_n   = dividend;
            cnt_n   = '0;
          end
        end
      end

      RUN: begin
        // Restore on borrow: keep the shifted remainder, quotient bit 0.
        rem_n = trial_ok ? trial_diff : rem_shift[WIDTH-1:0];
        quo_n = {quo_shift[WIDTH-1:1], trial_ok};
        cnt_n = cnt + CNT_W'(1);
        if (cnt == LAST_ITER) begin
          state_n         = DONE;
          done_n          = 1'b1;
          res_n.quotient  = quo_n;
          res_n.remainder = rem_n;
        end else begin
          busy_n = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign quotient    = res.quotient;
  assign remainder   = res.remainder;
  assign div_by_zero = res.div_by_zero;

endmodule : seq_divider8

// File: tb/tb_seq_divider8.sv
// Self-checking bench for seq_divider8: directed vectors with literal
// expectations plus a transaction-level model compared every cycle.
module tb_seq_divider8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  seq_divider8 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  // Transaction model: a request takes 8 busy cycles then a done cycle
  // (or a done cycle at once for a zero divisor); results from / and %.
  bit       m_busy = 1'b0;
  bit       m_done = 1'b0;
  bit       m_dz   = 1'b0;
  int       m_left = 0;
  bit [7:0] m_q    = 8'd0;
  bit [7:0] m_r    = 8'd0;
  bit [7:0] m_pq   = 8'd0;
  bit [7:0] m_pr   = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dz   = 1'b0;
      m_left = 0;
      m_q    = 8'd0;
      m_r    = 8'd0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_q    = m_pq;
        m_r    = m_pr;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      if (divisor == 8'd0) begin
        m_done = 1'b1;
        m_dz   = 1'b1;
        m_q    = 8'hFF;
        m_r    = dividend;
      end else begin
        m_dz   = 1'b0;
        m_busy = 1'b1;
        m_left = 8;
        m_pq   = 8'(int'(dividend) / int'(divisor));
        m_pr   = 8'(int'(dividend) % int'(divisor));
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("quotient", int'(quotient), int'(m_q));
      chk("remainder", int'(remainder), int'(m_r));
      chk("div_by_zero", int'(div_by_zero), int'(m_dz));
    end
  end

  // Wait for done from the current negedge; lat=1 means done seen now.
  task automatic wait_done(output int lat, output int bc);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    bc   = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      if (busy) bc++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bc);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;
    logic [7:0] dvs_list [12];

    dvs_list = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd10, 8'd15,
                 8'd16, 8'd99, 8'd127, 8'd128, 8'd200, 8'd255};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_dz", int'(div_by_zero), 0);
    rst = 1'b0;

    // 200 / 7
    do_div(8'd200, 8'd7, lat, bc);
    chk("lat_200_7", lat, 9);
    chk("busy_cycles_200_7", bc, 8);
    chk("q_200_7", int'(quotient), 28);
    chk("r_200_7", int'(remainder), 4);
    chk("dz_200_7", int'(div_by_zero), 0);

    // divisor of one, then dividend below divisor
    do_div(8'd255, 8'd1, lat, bc);
    chk("q_255_1", int'(quotient), 255);
    chk("r_255_1", int'(remainder), 0);
    do_div(8'd5, 8'd9, lat, bc);
    chk("q_5_9", int'(quotient), 0);
    chk("r_5_9", int'(remainder), 5);

    // divide by zero
    do_div(8'd37, 8'd0, lat, bc);
    chk("lat_37_0", lat, 1);
    chk("busy_cycles_37_0", bc, 0);
    chk("q_37_0", int'(quotient), 255);
    chk("r_37_0", int'(remainder), 37);
    chk("dz_37_0", int'(div_by_zero), 1);

    // start during RUN is ignored
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd10;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk("lat_restart_ignored", lat, 6);
    chk("q_100_10", int'(quotient), 10);
    chk("r_100_10", int'(remainder), 0);
    chk("dz_cleared", int'(div_by_zero), 0);
    do_div(8'd50, 8'd3, lat, bc);
    chk("q_50_3", int'(quotient), 16);
    chk("r_50_3", int'(remainder), 2);

    // reset mid-RUN abandons the division
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);
    do_div(8'd255, 8'd16, lat, bc);
    chk("q_255_16", int'(quotient), 15);
    chk("r_255_16", int'(remainder), 15);

    // sweep of every dividend against a spread of divisors, back to back
    foreach (dvs_list[k]) begin
      for (int a = 0; a < 256; a++) begin
        do_div(8'(a), dvs_list[k], lat, bc);
        chk("sweep_latency", lat, 9);
        chk("sweep_busy_cycles", bc, 8);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_divider8
